comparator_32bit_signed_lteq_serial_rx: RTL and testbench

COMPARATOR_32BIT_SIGNED_LTEQ_SERIAL_RX -- requirements
Module: comparator_32bit_signed_lteq_serial_rx

---
 rtl/comparator_32bit_signed_lteq_serial_rx_if.sv | 40 ++++
 rtl/comparator_32bit_signed_lteq_serial_rx.sv | 144 ++++++++++++++
 tb/tb_comparator_32bit_signed_lteq_serial_rx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_32bit_signed_lteq_serial_rx_if.sv
// comparator_32bit_signed_lteq_serial_rx_if
//
// Bundles the serial operand stream and the result handshake of the signed
// A <= B serial comparator.
//   Operand side : a_bit, b_bit, in_valid, in_first (to receiver), in_ready (from receiver)
//   Result side  : y0, out_valid, frame_err (from receiver), out_ready (to receiver)
//   Optional     : y_eq (A == B), present only when COMP_SERIAL_EQ_OUT_EN is defined
// Modports: slave = the comparator, master = the producer/consumer driving it.
interface comparator_32bit_signed_lteq_serial_rx_if;
    logic a_bit;
    logic b_bit;
    logic in_valid;
    logic in_first;
    logic in_ready;
    logic y0;
    logic out_valid;
    logic out_ready;
    logic frame_err;
`ifdef COMP_SERIAL_EQ_OUT_EN
    logic y_eq;

    modport slave (
        input  a_bit, b_bit, in_valid, in_first, out_ready,
        output in_ready, y0, out_valid, frame_err, y_eq
    );
    modport master (
        output a_bit, b_bit, in_valid, in_first, out_ready,
        input  in_ready, y0, out_valid, frame_err, y_eq
    );
`else
    modport slave (
        input  a_bit, b_bit, in_valid, in_first, out_ready,
        output in_ready, y0, out_valid, frame_err
    );
    modport master (
        output a_bit, b_bit, in_valid, in_first, out_ready,
        input  in_ready, y0, out_valid, frame_err
    );
`endif
endinterface

// File: rtl/comparator_32bit_signed_lteq_serial_rx.sv
// comparator_32bit_signed_lteq_serial_rx
//
// Receives two 32-bit two's-complement operands serially (LSB first, one bit
// of each per accepted beat) and reports A <= B (signed).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - comparator_32bit_signed_lteq_serial_rx_if.slave
//          in:  a_bit, b_bit, in_valid, in_first, out_ready
//          out: in_ready, y0, out_valid, frame_err (+ y_eq)
// Optional feature: define COMP_SERIAL_EQ_OUT_EN to add the y_eq (A == B)
// output, registered and held alongside y0.
//
// Comparison idea: walking LSB to MSB, the most significant differing bit
// decides the order, so every differing bit simply overwrites lt and clears
// eq. The sign bit inverts the sense (A=1, B=0 means A is negative, A < B).
module comparator_32bit_signed_lteq_serial_rx (
    input  logic clk,
    input  logic rst,
    comparator_32bit_signed_lteq_serial_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state_reg, state_next;
    logic [4:0] cnt_reg, cnt_next;
    logic       lt_reg, lt_next;
    logic       eq_reg, eq_next;
    logic       y0_reg, y0_next;
    logic       out_valid_reg, out_valid_next;
    logic       frame_err_reg, frame_err_next;
`ifdef COMP_SERIAL_EQ_OUT_EN
    logic       y_eq_reg, y_eq_next;
`endif

    logic accept;
    logic bit_ne;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 5'd0;
            lt_reg        <= 1'b0;
            eq_reg        <= 1'b0;
            y0_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef COMP_SERIAL_EQ_OUT_EN
            y_eq_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            lt_reg        <= lt_next;
            eq_reg        <= eq_next;
            y0_reg        <= y0_next;
            out_valid_reg <= out_valid_next;
            frame_err_reg <= frame_err_next;
`ifdef COMP_SERIAL_EQ_OUT_EN
            y_eq_reg      <= y_eq_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        lt_next        = lt_reg;
        eq_next        = eq_reg;
        y0_next        = y0_reg;
        out_valid_next = out_valid_reg;
        frame_err_next = 1'b0;
`ifdef COMP_SERIAL_EQ_OUT_EN
        y_eq_next      = y_eq_reg;
`endif
        // in_ready is low only in DONE, so a beat in DONE is never taken
        accept = bus.in_valid && (state_reg != DONE);
        bit_ne = bus.a_bit ^ bus.b_bit;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (bus.in_first) begin
                        lt_next    = ~bus.a_bit & bus.b_bit;
                        eq_next    = ~bit_ne;
                        cnt_next   = 5'd1;
                        state_next = SHIFT;
                    end else begin
                        // stray beat outside a frame: drop it and flag
                        frame_err_next = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (accept) begin
                    if (bus.in_first) begin
                        // restart: abandon the partial frame, this beat is bit 0
                        frame_err_next = 1'b1;
                        lt_next        = ~bus.a_bit & bus.b_bit;
                        eq_next        = ~bit_ne;
                        cnt_next       = 5'd1;
                    end else if (cnt_reg == 5'd31) begin
                        // sign bit: a set A bit against a clear B bit means A < B
                        if (bit_ne) begin
                            lt_next = bus.a_bit & ~bus.b_bit;
                            eq_next = 1'b0;
                        end
                        y0_next        = lt_next | eq_next;
`ifdef COMP_SERIAL_EQ_OUT_EN
                        y_eq_next      = eq_next;
`endif
                        out_valid_next = 1'b1;
                        cnt_next       = 5'd0;
                        state_next     = DONE;
                    end else begin
                        if (bit_ne) begin
                            lt_next = ~bus.a_bit & bus.b_bit;
                            eq_next = 1'b0;
                        end
                        cnt_next = cnt_reg + 5'd1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 5'd0;
            end
        endcase
    end

    assign bus.in_ready  = (state_reg != DONE);
    assign bus.y0        = y0_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.frame_err = frame_err_reg;
`ifdef COMP_SERIAL_EQ_OUT_EN
    assign bus.y_eq      = y_eq_reg;
`endif

endmodule

// File: tb/tb_comparator_32bit_signed_lteq_serial_rx.sv
// Self-checking bench for comparator_32bit_signed_lteq_serial_rx.
// Reference: signed integer comparison of the whole operands.
module tb_comparator_32bit_signed_lteq_serial_rx;
    logic clk;
    logic rst;

    comparator_32bit_signed_lteq_serial_rx_if bus ();

    comparator_32bit_signed_lteq_serial_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ferr_cnt = 0;
    int ov_rise_cnt = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // event counters sampled mid-cycle
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (bus.out_valid === 1'b1 && ov_prev !== 1'b1) ov_rise_cnt = ov_rise_cnt + 1;
        ov_prev = bus.out_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_le(input logic [31:0] a, input logic [31:0] b);
        return $signed(a) <= $signed(b);
    endfunction

    // present one beat and wait until it is accepted; returns at posedge+1
    task automatic send_bit(input logic a, input logic b, input logic first);
        logic rdy;
        int waited;
        waited = 0;
        bus.a_bit = a;
        bus.b_bit = b;
        bus.in_first = first;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) break;
            waited++;
            if (waited > 50) begin
                check("in_ready_timeout", 32'(rdy), 32'd1);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gap: 0 none, 1 one idle cycle after every bit, 2 random idle cycles
    task automatic send_bits(input logic [31:0] a, input logic [31:0] b, input int nbits,
                             input int gap, output int t0, output int t1);
        t0 = 0;
        t1 = 0;
        for (int i = 0; i < nbits; i++) begin
            send_bit(a[i], b[i], (i == 0));
            if (i == 0) t0 = cyc;
            t1 = cyc;
            if (i < nbits - 1) begin
                if (gap == 1) idle(1);
                else if (gap == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
    endtask

    // full frame followed by result check; result held 'hold' extra cycles
    task automatic run_frame(input logic [31:0] a, input logic [31:0] b, input int gap,
                             input int hold, input string tag);
        int t0, t1;
        logic exp_y;
        exp_y = model_le(a, b);
        bus.out_ready = (hold == 0);
        send_bits(a, b, 32, gap, t0, t1);
        if (gap == 0) check({tag, "_span"}, 32'(t1 - t0), 32'd31);
        if (gap == 1) check({tag, "_span"}, 32'(t1 - t0), 32'd62);
        @(negedge clk);
        check({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_y0"}, 32'(bus.y0), 32'(exp_y));
`ifdef COMP_SERIAL_EQ_OUT_EN
        check({tag, "_yeq"}, 32'(bus.y_eq), 32'(a == b));
`endif
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check({tag, "_hold_ov"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_y0"}, 32'(bus.y0), 32'(exp_y));
            check({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
        $display("[TB] frame %s a=%08h b=%08h y0=%0d expected=%0d", tag, a, b, bus.y0, exp_y);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int f0, r0, t0, t1;
        logic [31:0] a, b;
        rst = 1'b1;
        bus.a_bit = 1'b0;
        bus.b_bit = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ov", 32'(bus.out_valid), 32'd0);
        check("rst_y0", 32'(bus.y0), 32'd0);
        check("rst_rdy", 32'(bus.in_ready), 32'd1);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        @(posedge clk);
        #1;

        // directed cases
        run_frame(32'hFFFF_FFFF, 32'h0000_0000, 0, 0, "neg1_vs_0");
        run_frame(32'h7FFF_FFFF, 32'h8000_0000, 0, 0, "max_vs_min");
        run_frame(32'h8000_0000, 32'h7FFF_FFFF, 0, 0, "min_vs_max");
        run_frame(32'h1234_5678, 32'h1234_5678, 1, 0, "equal_gaps");

        // stray beat in IDLE
        f0 = ferr_cnt;
        r0 = ov_rise_cnt;
        send_bit(1'b1, 1'b0, 1'b0);
        idle(2);
        check("stray_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("stray_no_ov", 32'(ov_rise_cnt - r0), 32'd0);
        $display("[TB] stray beat frame_err pulses=%0d", ferr_cnt - f0);

        // restart at bit 10, then full frame 5 vs 3
        f0 = ferr_cnt;
        r0 = ov_rise_cnt;
        send_bits(32'hDEAD_BEEF, 32'h0BAD_F00D, 10, 0, t0, t1);
        run_frame(32'd5, 32'd3, 0, 0, "abort_5_vs_3");
        check("abort_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("abort_one_ov", 32'(ov_rise_cnt - r0), 32'd1);

        // consumer stall
        run_frame(32'h0000_0001, 32'h0000_0002, 0, 5, "stall5");

        // reset mid-frame
        f0 = ferr_cnt;
        send_bits(32'h0F0F_0F0F, 32'hF0F0_F0F0, 20, 0, t0, t1);
        pulse_rst();
        @(negedge clk);
        check("midrst_ov", 32'(bus.out_valid), 32'd0);
        check("midrst_rdy", 32'(bus.in_ready), 32'd1);
        check("midrst_ferr", 32'(ferr_cnt - f0), 32'd0);
        @(posedge clk);
        #1;
        run_frame(32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 0, "m2_vs_m2");

        // reset while a result is waiting
        bus.out_ready = 1'b0;
        send_bits(32'h0000_0010, 32'h0000_0001, 32, 0, t0, t1);
        @(negedge clk);
        check("donerst_pre_ov", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        pulse_rst();
        @(negedge clk);
        check("donerst_ov", 32'(bus.out_valid), 32'd0);
        check("donerst_rdy", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // randomized frames
        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = a ^ 32'h8000_0000;
                2: b = a ^ 32'h0000_0001;
                3: b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            run_frame(a, b, 2, $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
